// File: rtl/score_display_scan_if.sv
// Scoreboard display bus: BCD digits and blank in from the score counter,
// scanned anode/segment/dp drive and frame marker out to the board pins.
interface score_display_scan_if;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  // master: the score-counter / board side; slave: the scan driver
  modport master (
    output dig0, dig1, dig2, dig3, blank,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  dig0, dig1, dig2, dig3, blank,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/score_display_scan.sv
// Four-digit common-anode scan driver for the pong scoreboard: per-frame
// digit snapshot, anti-ghosting gap, leading-zero blanking, dash for non-BCD.
module score_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  score_display_scan_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    pos_q, pos_d;
  logic [3:0]    snap0_q, snap0_d;
  logic [3:0]    snap1_q, snap1_d;
  logic [3:0]    snap2_q, snap2_d;
  logic [3:0]    snap3_q, snap3_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  logic          pre_last;
  logic          load;
  logic [3:0]    cur;

  always_comb begin
    pre_last = (pre_q == PRE_MAX);
    load     = (pre_q == '0) && (pos_q == 2'd0);

    pre_d = pre_last ? '0 : pre_q + PW'(1);
    pos_d = pre_last ? pos_q + 2'd1 : pos_q;

    snap0_d = load ? bus.dig0 : snap0_q;
    snap1_d = load ? bus.dig1 : snap1_q;
    snap2_d = load ? bus.dig2 : snap2_q;
    snap3_d = load ? bus.dig3 : snap3_q;

    frame_tick_d = load;

    // Display data is always the snapshot, never the live inputs
    case (pos_q)
      2'd0:    cur = snap0_q;
      2'd1:    cur = snap1_q;
      2'd2:    cur = snap2_q;
      default: cur = snap3_q;
    endcase

    case (cur)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase

    // Odd positions are the tens digits of each player's score
    if (BLANK_LZ && pos_q[0] && (cur == 4'd0)) begin
      seg_d = 7'b1111111;
    end

    dp_d = (pos_q != 2'd2);

    // Last dwell cycle is dark so the next digit's data never ghosts
    if (pre_last || bus.blank) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << pos_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q        <= '0;
      pos_q        <= 2'd0;
      snap0_q      <= 4'd0;
      snap1_q      <= 4'd0;
      snap2_q      <= 4'd0;
      snap3_q      <= 4'd0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      pos_q        <= pos_d;
      snap0_q      <= snap0_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      snap3_q      <= snap3_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
